// File: rtl/mc_controller.sv
// mc_controller: main control unit of the multicycle MIPS core.
// A 12-state Moore FSM steps each instruction through the shared datapath.
// Control outputs are decoded combinationally from the registered state.
// Stalls wait on the memory-ready handshake in FETCH, MEMRD and MEMWR.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU function from the FSM's aluop class and the R-type funct field.
    function automatic logic [2:0] alu_decode(input logic [1:0] aluop, input logic [5:0] fn);
        logic [2:0] res;
        res = ALU_ADD;
        case (aluop)
            2'b00: res = ALU_ADD;
            2'b01: res = ALU_SUB;
            2'b10: begin
                case (fn)
                    FN_ADD:  res = ALU_ADD;
                    FN_SUB:  res = ALU_SUB;
                    FN_AND:  res = ALU_AND;
                    FN_OR:   res = ALU_OR;
                    FN_SLT:  res = ALU_SLT;
                    default: res = ALU_ADD;
                endcase
            end
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic       mem_ready_s;
    logic       pcwrite_s;
    logic       branch_s;
    logic [1:0] aluop_s;

    // While reset is held the handshake is ignored so no strobe can fire.
    assign mem_ready_s = memready & reset;

    // Next-state selection: dispatch, stalls and illegal-state recovery.
    always_comb begin
        state_next_s = FETCH;
        case (state_r)
            FETCH:   state_next_s = mem_ready_s ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next_s = MEMADR;
                    OP_RTYPE:     state_next_s = RTYPEEX;
                    OP_BEQ:       state_next_s = BEQEX;
                    OP_ADDI:      state_next_s = ADDIEX;
                    OP_J:         state_next_s = JEX;
                    default:      state_next_s = FETCH;
                endcase
            end
            MEMADR:  state_next_s = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_next_s = mem_ready_s ? MEMWB : MEMRD;
            MEMWR:   state_next_s = mem_ready_s ? FETCH : MEMWR;
            RTYPEEX: state_next_s = RTYPEWB;
            ADDIEX:  state_next_s = ADDIWB;
            MEMWB, RTYPEWB, BEQEX, ADDIWB, JEX: state_next_s = FETCH;
            default: state_next_s = FETCH;
        endcase
    end

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Moore output decode; anything not named for a state stays low.
    always_comb begin
        pcwrite_s = 1'b0;
        branch_s  = 1'b0;
        aluop_s   = 2'b00;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        iord      = 1'b0;
        memtoreg  = 1'b0;
        regdst    = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        case (state_r)
            FETCH: begin
                alusrcb   = 2'b01;
                irwrite   = mem_ready_s;
                pcwrite_s = mem_ready_s;
            end
            DECODE: alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop_s = 2'b10;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca  = 1'b1;
                aluop_s  = 2'b01;
                pcsrc    = 2'b01;
                branch_s = 1'b1;
            end
            ADDIWB: regwrite = 1'b1;
            JEX: begin
                pcsrc     = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: begin
                pcwrite_s = 1'b0;
            end
        endcase
    end

    assign pcen       = pcwrite_s | (branch_s & zero);
    assign alucontrol = alu_decode(aluop_s, funct);
    assign state      = state_r;

endmodule
